// File: rtl/execute_logic_arbiter_pkg.sv
// execute_logic_arbiter_pkg: shared instruction widths, logic opcodes and arbiter state type
package execute_logic_arbiter_pkg;
  localparam int LEN_OPECODE = 6;
  localparam int LEN_REG     = 32;
  localparam int LEN_IMM     = 16;
  localparam int LEN_IMM_EX  = 32;
  localparam int LEN_TAG     = 4;
  localparam logic [LEN_OPECODE-1:0] OPECODE_AND  = 6'h10;
  localparam logic [LEN_OPECODE-1:0] OPECODE_OR   = 6'h11;
  localparam logic [LEN_OPECODE-1:0] OPECODE_NOT  = 6'h12;
  localparam logic [LEN_OPECODE-1:0] OPECODE_XOR  = 6'h13;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SETL = 6'h14;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SETH = 6'h15;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/execute_logic_arbiter_if.sv
// execute_logic_arbiter_if: two-requester request bus plus single result bus
interface execute_logic_arbiter_if;
  import execute_logic_arbiter_pkg::*;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [2*LEN_OPECODE-1:0] req_opecode;
  logic [2*LEN_REG-1:0]     req_data_rd;
  logic [2*LEN_REG-1:0]     req_data_rs;
  logic [2*LEN_IMM_EX-1:0]  req_imm_ex;
  logic [2*LEN_TAG-1:0]     req_tag;
  logic                     res_valid;
  logic                     res_ready;
  logic [LEN_REG-1:0]       res_data;
  logic                     res_src;
  logic [LEN_TAG-1:0]       res_tag;
  logic                     res_err;
  modport slave (
    input  req_valid, req_opecode, req_data_rd, req_data_rs, req_imm_ex, req_tag, res_ready,
    output req_ready, res_valid, res_data, res_src, res_tag, res_err
  );
  modport master (
    output req_valid, req_opecode, req_data_rd, req_data_rs, req_imm_ex, req_tag, res_ready,
    input  req_ready, res_valid, res_data, res_src, res_tag, res_err
  );
endinterface

// File: rtl/execute_logic_arbiter_alu.sv
// execute_logic_arbiter_alu: combinational logic unit with illegal-opcode flag
module execute_logic_arbiter_alu
  import execute_logic_arbiter_pkg::*;
(
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_rs,
  input  logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic [LEN_REG-1:0]     data,
  output logic                   err
);
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (opecode)
      OPECODE_AND:  data = data_rd & data_rs;
      OPECODE_OR:   data = data_rd | data_rs;
      OPECODE_NOT:  data = ~data_rs;
      OPECODE_XOR:  data = data_rd ^ data_rs;
      OPECODE_SETL: data = {data_rs[LEN_REG-1:LEN_IMM], imm_ex[LEN_IMM-1:0]};
      OPECODE_SETH: data = {imm_ex[LEN_IMM-1:0], data_rs[LEN_REG-LEN_IMM-1:0]};
      default:      err  = 1'b1;
    endcase
  end
endmodule

// File: rtl/execute_logic_arbiter.sv
// execute_logic_arbiter: round-robin share of one logic unit between two requesters, one result register
// Optional accept/stall counters enabled by defining EXECUTE_LOGIC_ARB_STATS_EN.
module execute_logic_arbiter
  import execute_logic_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  execute_logic_arbiter_if.slave bus
`ifdef EXECUTE_LOGIC_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_stall
`endif
);
  state_t state, state_nx;
  logic last_grant, can_accept, accept, sel;
  logic [1:0] grant;
  logic [LEN_OPECODE-1:0] opc;
  logic [LEN_REG-1:0] rd, rs, alu_data;
  logic [LEN_IMM_EX-1:0] imm;
  logic [LEN_TAG-1:0] tag;
  logic alu_err;
  assign bus.res_valid = state == FULL;
  always_comb begin
    can_accept    = !bus.res_valid | bus.res_ready;
    grant         = &bus.req_valid ? (last_grant ? 2'b01 : 2'b10) : bus.req_valid;
    bus.req_ready = (can_accept & !flush) ? grant : 2'b00;
    accept        = |(bus.req_valid & bus.req_ready);
    sel           = grant[1];
    opc = sel ? bus.req_opecode[2*LEN_OPECODE-1:LEN_OPECODE] : bus.req_opecode[LEN_OPECODE-1:0];
    rd  = sel ? bus.req_data_rd[2*LEN_REG-1:LEN_REG] : bus.req_data_rd[LEN_REG-1:0];
    rs  = sel ? bus.req_data_rs[2*LEN_REG-1:LEN_REG] : bus.req_data_rs[LEN_REG-1:0];
    imm = sel ? bus.req_imm_ex[2*LEN_IMM_EX-1:LEN_IMM_EX] : bus.req_imm_ex[LEN_IMM_EX-1:0];
    tag = sel ? bus.req_tag[2*LEN_TAG-1:LEN_TAG] : bus.req_tag[LEN_TAG-1:0];
    // flush beats everything; otherwise a drain empties only when nothing replaces it
    state_nx = flush ? EMPTY : accept ? FULL : bus.res_ready ? EMPTY : state;
  end
  execute_logic_arbiter_alu u_alu (
    .opecode(opc),
    .data_rd(rd),
    .data_rs(rs),
    .imm_ex (imm),
    .data   (alu_data),
    .err    (alu_err)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= 1'b1;
      bus.res_data <= '0;
      bus.res_src  <= 1'b0;
      bus.res_tag  <= '0;
      bus.res_err  <= 1'b0;
    end else if (accept) begin
      last_grant   <= sel;
      bus.res_data <= alu_data;
      bus.res_src  <= sel;
      bus.res_tag  <= tag;
      bus.res_err  <= alu_err;
    end
  end
`ifdef EXECUTE_LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept & !sel) stat_grant0 <= stat_grant0 + 32'd1;
      if (accept & sel) stat_grant1 <= stat_grant1 + 32'd1;
      if (|bus.req_valid & !accept) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_execute_logic_arbiter.sv
// tb_execute_logic_arbiter: directed self-checking bench for execute_logic_arbiter
module tb_execute_logic_arbiter;
  import execute_logic_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [38:0] res;
  execute_logic_arbiter_if bus();
`ifdef EXECUTE_LOGIC_ARB_STATS_EN
  logic [31:0] sg0, sg1, ss;
`endif
  execute_logic_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
`ifdef EXECUTE_LOGIC_ARB_STATS_EN
    ,
    .stat_grant0(sg0),
    .stat_grant1(sg1),
    .stat_stall (ss)
`endif
  );
  assign res = {bus.res_valid, bus.res_src, bus.res_tag, bus.res_err, bus.res_data};
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] opc, input logic [31:0] rd, input logic [31:0] rs,
                         input logic [31:0] imm, input logic [3:0] tag);
    bus.req_opecode[i*LEN_OPECODE +: LEN_OPECODE] = opc;
    bus.req_data_rd[i*LEN_REG +: LEN_REG] = rd;
    bus.req_data_rs[i*LEN_REG +: LEN_REG] = rs;
    bus.req_imm_ex[i*LEN_IMM_EX +: LEN_IMM_EX] = imm;
    bus.req_tag[i*LEN_TAG +: LEN_TAG] = tag;
  endtask

  task automatic test_reset;
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;
    set_req(0, 6'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    set_req(1, 6'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (res !== 39'h0) begin errors++; $display("FAIL reset_res got=%h exp=%h", res, 39'h0); end
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_and;
    set_req(0, OPECODE_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 4'd3);
    bus.req_valid = 2'b01;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL and_ready got=%b exp=01", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    checks++;
    if (res !== {1'b1, 1'b0, 4'd3, 1'b0, 32'hF000F000})
      begin errors++; $display("FAIL and_res got=%h exp=%h", res, {1'b1, 1'b0, 4'd3, 1'b0, 32'hF000F000}); end
    tick;
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL and_drain got=%b exp=0", bus.res_valid); end
  endtask

  task automatic test_contention;
    logic [38:0] exp_res;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_req(0, OPECODE_OR, 32'h1, 32'h2, 32'h0, 4'd5);
    set_req(1, OPECODE_XOR, 32'hF, 32'h5, 32'h0, 4'd6);
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== (k[0] ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL contention_ready%0d got=%b exp=%b", k, bus.req_ready, k[0] ? 2'b10 : 2'b01); end
      tick;
      exp_res = k[0] ? {1'b1, 1'b1, 4'd6, 1'b0, 32'hA} : {1'b1, 1'b0, 4'd5, 1'b0, 32'h3};
      checks++;
      if (res !== exp_res) begin errors++; $display("FAIL contention_res%0d got=%h exp=%h", k, res, exp_res); end
    end
    bus.req_valid = 2'b00;
    tick;
  endtask

  task automatic test_backpressure;
    set_req(0, OPECODE_NOT, 32'h0, 32'h0000FFFF, 32'h0, 4'd1);
    bus.req_valid = 2'b01;
    bus.res_ready = 1'b1;
    tick;
    set_req(1, OPECODE_AND, 32'hFFFFFFFF, 32'h12345678, 32'h0, 4'd9);
    bus.req_valid = 2'b10;
    bus.res_ready = 1'b0;
    checks++;
    if (res !== {1'b1, 1'b0, 4'd1, 1'b0, 32'hFFFF0000})
      begin errors++; $display("FAIL bp_first got=%h exp=%h", res, {1'b1, 1'b0, 4'd1, 1'b0, 32'hFFFF0000}); end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got=%b exp=00", k, bus.req_ready); end
      tick;
      checks++;
      if (res !== {1'b1, 1'b0, 4'd1, 1'b0, 32'hFFFF0000})
        begin errors++; $display("FAIL bp_hold%0d got=%h exp=%h", k, res, {1'b1, 1'b0, 4'd1, 1'b0, 32'hFFFF0000}); end
    end
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    checks++;
    if (res !== {1'b1, 1'b1, 4'd9, 1'b0, 32'h12345678})
      begin errors++; $display("FAIL bp_res got=%h exp=%h", res, {1'b1, 1'b1, 4'd9, 1'b0, 32'h12345678}); end
    tick;
  endtask

  task automatic test_ops;
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b01;
    set_req(0, OPECODE_SETH, 32'h0, 32'h12345678, 32'h0000ABCD, 4'd2);
    tick;
    checks++;
    if (res !== {1'b1, 1'b0, 4'd2, 1'b0, 32'hABCD5678})
      begin errors++; $display("FAIL seth got=%h exp=%h", res, {1'b1, 1'b0, 4'd2, 1'b0, 32'hABCD5678}); end
    set_req(0, OPECODE_SETL, 32'h0, 32'h12345678, 32'h0000ABCD, 4'd4);
    tick;
    checks++;
    if (res !== {1'b1, 1'b0, 4'd4, 1'b0, 32'h1234ABCD})
      begin errors++; $display("FAIL setl got=%h exp=%h", res, {1'b1, 1'b0, 4'd4, 1'b0, 32'h1234ABCD}); end
    set_req(0, 6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7);
    tick;
    checks++;
    if (res !== {1'b1, 1'b0, 4'd7, 1'b1, 32'h0})
      begin errors++; $display("FAIL illegal got=%h exp=%h", res, {1'b1, 1'b0, 4'd7, 1'b1, 32'h0}); end
    bus.req_valid = 2'b00;
    tick;
  endtask

  task automatic test_flush;
    set_req(0, OPECODE_XOR, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0, 4'd8);
    bus.req_valid = 2'b01;
    bus.res_ready = 1'b1;
    tick;
    set_req(1, OPECODE_OR, 32'h00000011, 32'h00000100, 32'h0, 4'd10);
    bus.req_valid = 2'b10;
    bus.res_ready = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready got=%b exp=00", bus.req_ready); end
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_override got=%b exp=00", bus.req_ready); end
    tick;
    flush = 1'b0;
    checks++;
    if (res !== {1'b0, 1'b0, 4'd8, 1'b0, 32'hF0F0F0F0})
      begin errors++; $display("FAIL flush_res got=%h exp=%h", res, {1'b0, 1'b0, 4'd8, 1'b0, 32'hF0F0F0F0}); end
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL flush_rr got=%b exp=10", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;
    tick;
    checks++;
    if (res !== {1'b1, 1'b1, 4'd10, 1'b0, 32'h00000111})
      begin errors++; $display("FAIL hold_res got=%h exp=%h", res, {1'b1, 1'b1, 4'd10, 1'b0, 32'h00000111}); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res !== 39'h0) begin errors++; $display("FAIL async_rst got=%h exp=%h", res, 39'h0); end
    rst = 1'b0;
    tick;
  endtask

`ifdef EXECUTE_LOGIC_ARB_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    set_req(0, OPECODE_AND, 32'h1, 32'h1, 32'h0, 4'd1);
    set_req(1, OPECODE_OR, 32'h1, 32'h2, 32'h0, 4'd2);
    bus.req_valid = 2'b01;
    repeat (3) tick;
    bus.req_valid = 2'b10;
    repeat (2) tick;
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b01;
    repeat (4) tick;
    bus.req_valid = 2'b00;
    checks++;
    if ({sg0, sg1, ss} !== {32'd3, 32'd2, 32'd4})
      begin errors++; $display("FAIL stats got=%0d/%0d/%0d exp=3/2/4", sg0, sg1, ss); end
  endtask
`endif

  initial begin
    test_reset;
    test_and;
    test_contention;
    test_backpressure;
    test_ops;
    test_flush;
`ifdef EXECUTE_LOGIC_ARB_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_logic_arbiter.md
Name: execute_logic_arbiter

Overview:
- Shares one combinational logic unit (AND/OR/NOT/XOR/SETL/SETH) between two requesters, e.g. two issue slots or hart contexts.
- Round-robin arbitration, valid/ready handshake on both sides, one registered result stage.
- Tags each result with its source and an illegal-opcode flag.
- Sits between issue and writeback in the execute stage.

Parameters:
- LEN_OPECODE, 6, opcode width (shared insn defs)
- LEN_REG, 32, register width
- LEN_IMM, 16, immediate field width used by SETL/SETH
- LEN_IMM_EX, 32, extended immediate width
- LEN_TAG, 4, opaque requester tag width (destination reg index / ROB id)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of held result and arbitration
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept
- req_opecode  in  2*LEN_OPECODE  opcode; requester i in slice i
- req_data_rd  in  2*LEN_REG  rd operand
- req_data_rs  in  2*LEN_REG  rs operand
- req_imm_ex  in  2*LEN_IMM_EX  extended immediate
- req_tag  in  2*LEN_TAG  tag returned with result
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  LEN_REG  result value
- res_src  out  1  granted requester index
- res_tag  out  LEN_TAG  tag of granted request
- res_err  out  1  opcode was not a logic opcode

Behaviour:
- Reset (async, rst=1): res_valid=0, res_data=0, res_src=0, res_tag=0, res_err=0, last_grant=1, so requester 0 wins first.
- can_accept = !res_valid | res_ready.
- Grant rule:
  - Only one requester valid: that requester is granted.
  - Both valid: grant !last_grant.
  - None valid: no grant.
- req_ready[i] = grant[i] & can_accept & !flush. At most one bit is set per cycle.
- req_ready may depend combinationally on req_valid. Requesters must not make valid depend on ready.
- Requesters hold all fields stable while valid & !ready. Valid must not drop before acceptance.
- Accept edge (req_valid[i] & req_ready[i]):
  - res_data <= logic result of slice i.
  - res_src <= i, res_tag <= tag i, res_valid <= 1, last_grant <= i.
- Latency 1 cycle, request to res_valid. Throughput 1/cycle: a new accept in the same cycle as res_ready overwrites with no bubble.
- Consumer drain without a new accept: res_valid <= 0. Data/tag/src retain their last values (don't-care).
- Holding (res_valid & !res_ready): all res_* stable. No new grant. last_grant unchanged.
- Logic ops: AND rd&rs; OR rd|rs; NOT ~rs; XOR rd^rs.
  - SETL = {rs[LEN_REG-1:LEN_IMM], imm_ex[LEN_IMM-1:0]}.
  - SETH = {imm_ex[LEN_IMM-1:0], rs[LEN_REG-LEN_IMM-1:0]}.
- Any other opcode: res_err=1, res_data=0 (never X). The request is still accepted and returned.
- flush=1: res_valid <= 0 next edge, no accept that cycle, last_grant unchanged. flush overrides res_ready.
- rst asserted mid-hold: the result is lost. Outputs go to reset values immediately.
- States:
  - EMPTY (res_valid=0)
  - FULL (res_valid=1)
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with res_ready, or hold.
  - FULL→EMPTY on res_ready without accept, or on flush.
  - EMPTY→EMPTY otherwise.

Optional Feature:
- Macro EXECUTE_LOGIC_ARB_STATS_EN.
- When defined:
  - Adds output stat_grant0 (32) and stat_grant1 (32): accept counts per requester.
  - Adds output stat_stall (32): cycles with any req_valid & no accept.
  - Counters wrap at 2^32, reset to 0 by rst, unaffected by flush.
- When undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared insn defs include supplies OPECODE_* constants and the LEN_* defaults.
- Add LEN_TAG there.
- Natural sub-module: the existing combinational logic unit, instantiated once on the muxed granted request, extended with an err output (or err decoded locally).
- Round-robin grant kept inline.

Test Plan:
- Single AND: req0 rd=0xF0F0F0F0, rs=0xFF00FF00, tag=3; res_ready=1. Next cycle: res_valid=1, data=0xF000F000, src=0, tag=3, err=0.
- Contention: both valid every cycle, res_ready=1. Grants go 0,1,0,1. Results back-to-back, no bubbles.
- Backpressure: res_ready=0 for 5 cycles with req1 valid. res_* stable and req_ready=00. On res_ready=1 the same cycle accepts req1; its result appears next cycle.
- SETH rs=0x12345678, imm_ex=0x0000ABCD → 0xABCD5678. SETL → 0x1234ABCD. Illegal opcode → err=1, data=0.
- flush while FULL with res_ready=0 → res_valid=0 next cycle and no accept that cycle. Async rst mid-hold → all outputs 0 without a clock edge.
- With EXECUTE_LOGIC_ARB_STATS_EN: 3 grants to req0, 2 to req1, 4 stall cycles → counters read 3/2/4.
